xcorr_peak_scheduler: RTL and testbench

XCORR_PEAK_SCHEDULER -- requirements
Module: xcorr_peak_scheduler

---
 rtl/xcorr_peak_scheduler.sv | 178 +++++++++++++++++
 tb/tb_xcorr_peak_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xcorr_peak_scheduler.sv
// xcorr_peak_scheduler: windowed, decimated peak search over cross-correlation
// vectors. Fills a window, then snapshots all pairs on every DECIMATION-th
// update and scans them serially (one lag compare per cycle) for the peak.
// Ports: clk, rst (async active-low), enable (low = soft restart),
//   xCorrValid (update pulse), xCorrIn0..5 (live lag vectors, index 0 = -MAXD),
//   resultReady (consumer accept), resultValid (result held until accepted),
//   lagOut/peakOut (per-pair peak lag and value), busy (SCAN or DONE),
//   overrunCount (saturating count of triggers dropped while busy).
module xcorr_peak_scheduler #(
  parameter int NUM_BITS_XCORR = 32,
  parameter int MAX_SAMPLES_DELAY = 9,
  parameter int NUM_XCORRS = 6,
  parameter int NUM_SAMPLES = 1024,
  parameter int DECIMATION = 64,
  localparam int NUM_LAGS = 2*MAX_SAMPLES_DELAY+1,
  localparam int LAG_BITS = $clog2(NUM_LAGS)+1
)(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic xCorrValid,
  input  logic [NUM_LAGS-1:0][NUM_BITS_XCORR-1:0] xCorrIn0,
  input  logic [NUM_LAGS-1:0][NUM_BITS_XCORR-1:0] xCorrIn1,
  input  logic [NUM_LAGS-1:0][NUM_BITS_XCORR-1:0] xCorrIn2,
  input  logic [NUM_LAGS-1:0][NUM_BITS_XCORR-1:0] xCorrIn3,
  input  logic [NUM_LAGS-1:0][NUM_BITS_XCORR-1:0] xCorrIn4,
  input  logic [NUM_LAGS-1:0][NUM_BITS_XCORR-1:0] xCorrIn5,
  input  logic resultReady,
  output logic resultValid,
  output logic [NUM_XCORRS-1:0][LAG_BITS-1:0] lagOut,
  output logic [NUM_XCORRS-1:0][NUM_BITS_XCORR-1:0] peakOut,
  output logic busy,
  output logic [7:0] overrunCount
);

  localparam int LIDX_BITS = $clog2(NUM_LAGS);
  localparam int PAIR_BITS = $clog2(NUM_XCORRS+1);
  localparam int FILL_BITS = $clog2(NUM_SAMPLES+1);
  localparam int DEC_BITS = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LIDX_BITS-1:0] LAG_LAST =
    LIDX_BITS'(NUM_LAGS-1);
  localparam logic [FILL_BITS-1:0] FILL_LAST =
    FILL_BITS'(NUM_SAMPLES-1);
  localparam logic [DEC_BITS-1:0] DEC_LAST =
    DEC_BITS'(DECIMATION-1);
  localparam logic [PAIR_BITS-1:0] PAIR_END =
    PAIR_BITS'(NUM_XCORRS);

  typedef logic [NUM_LAGS-1:0][NUM_BITS_XCORR-1:0] vec_t;

  logic [1:0] state;
  logic [FILL_BITS-1:0] fill_cnt;
  logic [DEC_BITS-1:0] decim_cnt;
  logic [PAIR_BITS-1:0] pair;
  logic [LIDX_BITS-1:0] lag;
  logic [LIDX_BITS-1:0] max_idx;
  logic [NUM_BITS_XCORR-1:0] max_val;
  vec_t snap [6];

  logic trig;
  logic win;
  logic [NUM_BITS_XCORR-1:0] cur;
  logic [NUM_BITS_XCORR-1:0] nxt_max;
  logic [LIDX_BITS-1:0] nxt_idx;
  logic [LAG_BITS-1:0] lag_res;

  // Trigger only exists once the window is full and the engine is enabled.
  assign trig = enable && xCorrValid && (state != S_FILL) &&
                (decim_cnt == DEC_LAST);

  assign busy = (state == S_SCAN) || (state == S_DONE);

  always_comb begin
    cur = '0;
    for (int p = 0; p < 6; p++) begin
      if (pair == PAIR_BITS'(p)) cur = snap[p][lag];
    end
  end

  // Lag 0 seeds the running max; strict > keeps the lowest index on ties.
  assign win = (lag == '0) || ($signed(cur) > $signed(max_val));
  assign nxt_max = win ? cur : max_val;
  assign nxt_idx = win ? lag : max_idx;
  assign lag_res = LAG_BITS'(nxt_idx) - LAG_BITS'(MAX_SAMPLES_DELAY);

  // Snapshot is pure data; no reset needed.
  always_ff @(posedge clk) begin
    if (trig && state == S_ARMED) begin
      snap[0] <= xCorrIn0;
      snap[1] <= xCorrIn1;
      snap[2] <= xCorrIn2;
      snap[3] <= xCorrIn3;
      snap[4] <= xCorrIn4;
      snap[5] <= xCorrIn5;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FILL;
      fill_cnt <= '0;
      decim_cnt <= '0;
      pair <= '0;
      lag <= '0;
      max_idx <= '0;
      max_val <= '0;
      resultValid <= 1'b0;
      lagOut <= '0;
      peakOut <= '0;
      overrunCount <= '0;
    end else if (!enable) begin
      state <= S_FILL;
      fill_cnt <= '0;
      decim_cnt <= '0;
      resultValid <= 1'b0;
    end else begin
      if (xCorrValid && state != S_FILL) begin
        decim_cnt <= (decim_cnt == DEC_LAST) ?
                     '0 : decim_cnt + 1'b1;
      end
      if (trig && busy && overrunCount != 8'hFF) begin
        overrunCount <= overrunCount + 8'd1;
      end
      case (state)
        S_FILL: begin
          if (xCorrValid) begin
            if (fill_cnt == FILL_LAST) begin
              state <= S_ARMED;
              fill_cnt <= '0;
              decim_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (trig) begin
            state <= S_SCAN;
            pair <= '0;
            lag <= '0;
          end
        end
        S_SCAN: begin
          // Extra step after the last pair gives the +1 cycle of latency.
          if (pair == PAIR_END) begin
            state <= S_DONE;
            resultValid <= 1'b1;
          end else begin
            max_val <= nxt_max;
            max_idx <= nxt_idx;
            if (lag == LAG_LAST) begin
              lag <= '0;
              pair <= pair + 1'b1;
              lagOut[pair] <= lag_res;
              peakOut[pair] <= nxt_max;
            end else begin
              lag <= lag + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (resultReady) begin
            state <= S_ARMED;
            resultValid <= 1'b0;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_xcorr_peak_scheduler.sv
// tb_xcorr_peak_scheduler: directed bench with expected-result scoreboard
// for xcorr_peak_scheduler (NUM_SAMPLES=16, DECIMATION=4).
module tb_xcorr_peak_scheduler;

  localparam int NL = 19;

  typedef struct packed {
    logic [5:0][5:0] lag;
    logic [5:0][31:0] peak;
  } res_t;

  logic clk;
  logic rst;
  logic enable;
  logic xv;
  logic ready;
  logic rv;
  logic busy;
  logic [7:0] ovr;
  logic [5:0][5:0] lag_o;
  logic [5:0][31:0] peak_o;
  logic [NL-1:0][31:0] xin [6];

  int compared = 0;
  int mismatched = 0;
  res_t exp_q [$];
  logic rv_q = 1'b0;

  xcorr_peak_scheduler #(
    .NUM_BITS_XCORR(32),
    .MAX_SAMPLES_DELAY(9),
    .NUM_XCORRS(6),
    .NUM_SAMPLES(16),
    .DECIMATION(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .xCorrValid(xv),
    .xCorrIn0(xin[0]),
    .xCorrIn1(xin[1]),
    .xCorrIn2(xin[2]),
    .xCorrIn3(xin[3]),
    .xCorrIn4(xin[4]),
    .xCorrIn5(xin[5]),
    .resultReady(ready),
    .resultValid(rv),
    .lagOut(lag_o),
    .peakOut(peak_o),
    .busy(busy),
    .overrunCount(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every new result presentation is checked against the queue.
  always @(negedge clk) begin
    if (rv && !rv_q) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL result_unexpected: got lag=%h peak=%h, none expected",
                 lag_o, peak_o);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        if (lag_o !== e.lag || peak_o !== e.peak) begin
          mismatched++;
          $display("FAIL result: got lag=%h peak=%h, want lag=%h peak=%h",
                   lag_o, peak_o, e.lag, e.peak);
        end
      end
    end
    rv_q = rv;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)",
               nm, $signed(act), act, $signed(want), want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    xv = 1'b1;
    @(posedge clk);
    #1;
    xv = 1'b0;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      pulse();
      idle(1);
    end
  endtask

  task automatic wait_result(input string nm);
    int n = 0;
    while (!rv && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(n), 32'd115);
  endtask

  task automatic pat_a();
    for (int k = 0; k < 6; k++)
      for (int l = 0; l < NL; l++)
        xin[k][l] = (l == 3 + k) ? 32'sd1000 : -32'sd5;
  endtask

  task automatic pat_c();
    for (int k = 0; k < 5; k++)
      for (int l = 0; l < NL; l++)
        xin[k][l] = (l == 18 - k) ? 32'sd500 : -32'sd100000;
    for (int l = 0; l < NL; l++)
      xin[5][l] = (l == 13) ? -32'sd3 : -32'sd100;
  endtask

  res_t ea;
  res_t eb;
  res_t ec;

  initial begin
    logic stable;

    for (int k = 0; k < 6; k++) begin
      ea.lag[k] = 6'(k - 6);
      ea.peak[k] = 32'd1000;
      ec.lag[k] = 6'(9 - k);
      ec.peak[k] = 32'd500;
    end
    ec.lag[5] = 6'd4;
    ec.peak[5] = -32'sd3;
    eb = ea;
    eb.lag[0] = -6'sd9;
    eb.peak[0] = 32'd7;

    rst = 1'b0;
    enable = 1'b1;
    xv = 1'b0;
    ready = 1'b0;
    pat_a();
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(rv), 32'd0);
    chk("reset_lag", 32'(lag_o), 32'd0);
    chk("reset_peak", 32'(|peak_o), 32'd0);
    chk("reset_ovr", 32'(ovr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Window fill, then three updates short of a trigger.
    pulses(16);
    chk("fill_busy", 32'(busy), 32'd0);
    pulses(3);
    chk("armed_busy", 32'(busy), 32'd0);
    exp_q.push_back(ea);
    pulse();
    chk("trig_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 6; k++)
      for (int l = 0; l < NL; l++)
        xin[k][l] = 32'sd99999;
    wait_result("latency_a");

    // Consumer stalls while triggers keep arriving.
    stable = 1'b1;
    for (int c = 0; c < 200; c++) begin
      xv = (c % 25 == 0);
      @(posedge clk);
      #1;
      xv = 1'b0;
      if (!rv || lag_o !== ea.lag || peak_o !== ea.peak) stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 32'd1);
    chk("overrun", 32'(ovr), 32'd2);
    ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_valid", 32'(rv), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);

    // Tie on pair 0 resolves to the lowest lag.
    pat_a();
    for (int l = 0; l < NL; l++) xin[0][l] = 32'sd7;
    exp_q.push_back(eb);
    pulses(3);
    pulse();
    wait_result("latency_b");
    idle(1);
    chk("done_to_armed", 32'(busy), 32'd0);

    // Soft restart aborts a scan in progress.
    pulses(3);
    pulse();
    chk("scan2_busy", 32'(busy), 32'd1);
    idle(20);
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    chk("soft_busy", 32'(busy), 32'd0);
    chk("soft_valid", 32'(rv), 32'd0);
    chk("soft_lag_held", 32'($signed(lag_o[0])), -32'sd9);
    chk("soft_ovr_held", 32'(ovr), 32'd2);
    pat_c();
    pulses(19);
    chk("refill_busy", 32'(busy), 32'd0);
    exp_q.push_back(ec);
    pulse();
    chk("refill_trig", 32'(busy), 32'd1);
    wait_result("latency_c");
    idle(2);

    // Asynchronous reset mid-scan.
    pulses(3);
    pulse();
    idle(30);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(rv), 32'd0);
    chk("arst_lag", 32'(|lag_o), 32'd0);
    chk("arst_peak", 32'(|peak_o), 32'd0);
    chk("arst_ovr", 32'(ovr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    pulses(19);
    chk("post_rst_busy", 32'(busy), 32'd0);
    exp_q.push_back(ec);
    pulse();
    wait_result("latency_d");
    idle(5);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
